// File: rtl/period_meter_pkg.sv
// Shared types and default constants for the period meter and its synchronizer.
// Optional averager is enabled by defining PERIOD_METER_AVG_EN.
package period_meter_pkg;

   typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

   localparam int CNT_W_DEF       = 31;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int TIMEOUT_DEF     = 1000000;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, followed by single-cycle
// rise and fall pulses taken from the synchronized level.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_level;

   assign w_level = r_sync[SYNC_STAGES-1];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
         r_prev <= w_level;
      end
   end

   assign o_rise = w_level & ~r_prev;
   assign o_fall = ~w_level & r_prev;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous signal in clk_in cycles.
// Define PERIOD_METER_AVG_EN to add a four-period running average output.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             enable,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             timeout
`ifdef PERIOD_METER_AVG_EN
   ,
   output logic [CNT_W-1:0] avg_period,
   output logic             avg_valid
`endif
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_hiLat;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_highTime;
   logic             r_valid;
   logic             r_timeout;

   logic w_rise;
   logic w_fall;
   logic w_capture;
   logic w_timeoutHit;

   sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .i_clk (clk_in),
      .i_rst (rst),
      .i_sig (sig_in),
      .o_rise(w_rise),
      .o_fall(w_fall)
   );

   // A rise always beats the timeout check when both land on the same cycle.
   assign w_capture    = enable && (r_state == MEAS) && w_rise;
   assign w_timeoutHit = enable && (r_state == MEAS) && !w_rise && (r_cnt == TIMEOUT_C);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_hiLat    <= '0;
         r_period   <= '0;
         r_highTime <= '0;
         r_valid    <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (!enable) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_cnt   <= '0;
                  r_state <= ARM;
               end
               ARM: begin
                  if (w_rise) begin
                     r_cnt   <= ONE_C;
                     r_hiLat <= '0;
                     r_state <= MEAS;
                  end
               end
               MEAS: begin
                  if (w_capture) begin
                     r_period   <= r_cnt;
                     r_highTime <= r_hiLat;
                     r_valid    <= 1'b1;
                     r_timeout  <= 1'b0;
                     r_cnt      <= ONE_C;
                     r_hiLat    <= '0;
                  end else if (w_timeoutHit) begin
                     r_timeout <= 1'b1;
                     r_cnt     <= '0;
                     r_state   <= ARM;
                  end else begin
                     r_cnt <= r_cnt + ONE_C;
                     if (w_fall) begin
                        r_hiLat <= r_cnt;
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign period    = r_period;
   assign high_time = r_highTime;
   assign valid     = r_valid;
   assign timeout   = r_timeout;

`ifdef PERIOD_METER_AVG_EN
   logic [CNT_W-1:0] r_hist [4];
   logic [2:0]       r_histCnt;
   logic             r_avgValid;
   logic [CNT_W+1:0] w_sum;

   // History only counts periods captured since the last arm, so any event
   // that forces a re-arm also empties it.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) r_hist[i] <= '0;
         r_histCnt  <= '0;
         r_avgValid <= 1'b0;
      end else begin
         r_avgValid <= 1'b0;
         if (!enable || w_timeoutHit) begin
            for (int i = 0; i < 4; i++) r_hist[i] <= '0;
            r_histCnt <= '0;
         end else if (w_capture) begin
            r_hist[0] <= r_cnt;
            r_hist[1] <= r_hist[0];
            r_hist[2] <= r_hist[1];
            r_hist[3] <= r_hist[2];
            if (r_histCnt < 3'd4) begin
               r_histCnt <= r_histCnt + 3'd1;
            end
            r_avgValid <= (r_histCnt >= 3'd3);
         end
      end
   end

   assign w_sum = {2'b00, r_hist[0]} + {2'b00, r_hist[1]}
                + {2'b00, r_hist[2]} + {2'b00, r_hist[3]};

   assign avg_period = w_sum[CNT_W+1:2];
   assign avg_valid  = r_avgValid;
`endif

endmodule
